// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM states, opcode fields, table geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

  localparam int INST_W  = 9;
  localparam int LUT_AW  = 5;
  localparam int LUT_DEP = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // inst[8:5] value that ends the program
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Branch kinds carried in inst[7:5]; the decoder resolves them into branch_en
  localparam logic [2:0] BR_OP_BEQ = 3'b001;
  localparam logic [2:0] BR_OP_BNE = 3'b010;
  localparam logic [2:0] BR_OP_JMP = 3'b011;

  function automatic logic is_halt(input logic [INST_W-1:0] word);
    return word[8:5] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: instruction memory port plus the decoder-facing instruction stream.
// Latency: purely wires; memory read is combinational at imem_addr.
// Backpressure: stall from the decoder freezes the stream; no other flow control.
interface instr_fetch_if #(
  parameter int PC_W = 10
);
  logic [PC_W-1:0]                    imem_addr;
  logic [instr_fetch_pkg::INST_W-1:0] imem_data;
  logic [instr_fetch_pkg::INST_W-1:0] inst;
  logic                               inst_valid;
  logic                               stall;
  logic                               branch_en;

  modport master (
    output imem_addr, inst, inst_valid,
    input  imem_data, stall, branch_en
  );

  modport slave (
    input  imem_addr, inst, inst_valid,
    output imem_data, stall, branch_en
  );
endinterface

// File: rtl/instr_fetch_branch_lut.sv
// 32-entry branch target table, synchronous write, combinational read.
// Latency: read 0 cycles; a write is visible from the cycle after it (same-cycle read sees old data).
// Backpressure: none; writes always accepted.
module branch_lut
  import instr_fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  logic [PC_W-1:0] mem_q [LUT_DEP];

  // Table storage; contents are left unreset and must be loaded before use
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, IDLE/RUN/DONE control, branch redirect and retired count.
// Latency: inst follows pc combinationally; a taken branch redirects pc on the next cycle.
// Backpressure: stall holds pc, state and retired count and deasserts inst_valid.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                lut_we,
  input  logic [LUT_AW-1:0]   lut_addr,
  input  logic [PC_W-1:0]     lut_data,
  output logic                done,
  output logic [CNT_W-1:0]    retired,
  instr_fetch_if.master       bus
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  lut_rdata;
  logic             run_now;

  // Reset also blocks table writes so a reset cycle never corrupts targets
  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .clk   (clk),
    .we    (lut_we & ~reset),
    .waddr (lut_addr),
    .wdata (lut_data),
    .raddr (bus.imem_data[LUT_AW-1:0]),
    .rdata (lut_rdata)
  );

  // Next-state, next-pc and retired-count selection
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (retired_q != '1) begin
            retired_d = retired_q + CNT_W'(1);
          end
          if (is_halt(bus.imem_data)) begin
            state_d = ST_DONE;
          end else if (bus.branch_en) begin
            pc_d = lut_rdata;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  // Control registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      done_q    <= done_d;
    end
  end

  // Stream is blanked while reset is held so the decoder never sees a stale instruction
  assign run_now        = (state_q == ST_RUN) & ~reset;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = run_now ? bus.imem_data : '0;
  assign bus.inst_valid = run_now & ~bus.stall;
  assign done           = done_q & ~reset;
  assign retired        = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential run, branch, stall, reset, collision, wrap/saturation.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall driven directly by the bench.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [8:0] NOP     = 9'h001;
  localparam logic [8:0] HALT    = 9'h1E0;
  localparam logic [8:0] BR_K3   = 9'h163;
  localparam logic [8:0] TGT_OP  = 9'h0AA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic        lut_we_a, lut_we_b;
  logic [4:0]  lut_addr_a, lut_addr_b;
  logic [9:0]  lut_data_a;
  logic [3:0]  lut_data_b;
  logic        done_a, done_b;
  logic [15:0] retired_a;
  logic [3:0]  retired_b;

  logic [8:0] rom_a [1024];
  logic [8:0] rom_b [16];

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_if #(.PC_W(10)) bus_a ();
  instr_fetch_if #(.PC_W(4))  bus_b ();

  assign bus_a.imem_data = rom_a[bus_a.imem_addr];
  assign bus_b.imem_data = rom_b[bus_b.imem_addr];

  instr_fetch #(.PC_W(10), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .lut_we(lut_we_a), .lut_addr(lut_addr_a), .lut_data(lut_data_a),
    .done(done_a), .retired(retired_a), .bus(bus_a.master)
  );

  instr_fetch #(.PC_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .lut_we(lut_we_b), .lut_addr(lut_addr_b), .lut_data(lut_data_b),
    .done(done_b), .retired(retired_b), .bus(bus_b.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    lut_we_a = 1'b0; lut_addr_a = '0; lut_data_a = '0;
    lut_we_b = 1'b0; lut_addr_b = '0; lut_data_b = '0;
    bus_a.stall = 1'b0; bus_a.branch_en = 1'b0;
    bus_b.stall = 1'b0; bus_b.branch_en = 1'b0;
    for (int i = 0; i < 1024; i++) rom_a[i] = NOP;
    for (int i = 0; i < 16; i++) rom_b[i] = 9'h002;
    rom_a[4] = HALT;

    // Reset state
    tick(); tick();
    check("rst_pc",    32'(bus_a.imem_addr), 32'd0);
    check("rst_valid", 32'(bus_a.inst_valid), 32'd0);
    check("rst_inst",  32'(bus_a.inst), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_ret",   32'(retired_a), 32'd0);

    // Sequential run to HALT at address 4
    reset = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("seq_pc0",    32'(bus_a.imem_addr), 32'd0);
    check("seq_valid",  32'(bus_a.inst_valid), 32'd1);
    check("seq_inst0",  32'(bus_a.inst), 32'(NOP));
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc", 32'(bus_a.imem_addr), 32'(i));
    end
    check("seq_halt_inst", 32'(bus_a.inst), 32'(HALT));
    tick();
    check("seq_done",   32'(done_a), 32'd1);
    check("seq_ret",    32'(retired_a), 32'd5);
    check("seq_pchold", 32'(bus_a.imem_addr), 32'd4);
    check("seq_dvalid", 32'(bus_a.inst_valid), 32'd0);
    check("seq_dinst",  32'(bus_a.inst), 32'd0);

    // Taken branch: lut[3]=20, branch at address 2; table written while DONE
    rom_a[4]  = NOP;
    rom_a[2]  = BR_K3;
    rom_a[20] = TGT_OP;
    rom_a[21] = HALT;
    lut_we_a = 1'b1; lut_addr_a = 5'd3; lut_data_a = 10'd20;
    tick();
    lut_we_a = 1'b0;
    check("lutwr_done", 32'(done_a), 32'd1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("rs_pc",   32'(bus_a.imem_addr), 32'd0);
    check("rs_ret",  32'(retired_a), 32'd0);
    check("rs_done", 32'(done_a), 32'd0);
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;   // start while running has no effect
    check("run_start_ign", 32'(bus_a.imem_addr), 32'd2);
    check("br_inst", 32'(bus_a.inst), 32'(BR_K3));
    check("br_op",   32'(bus_a.inst[7:5]), 32'(BR_OP_JMP));
    bus_a.branch_en = 1'b1; tick(); bus_a.branch_en = 1'b0;
    check("br_pc",   32'(bus_a.imem_addr), 32'd20);
    check("br_tinst", 32'(bus_a.inst), 32'(TGT_OP));
    tick(); tick();
    check("br_done", 32'(done_a), 32'd1);
    check("br_ret",  32'(retired_a), 32'd5);
    check("br_pchold", 32'(bus_a.imem_addr), 32'd21);

    // Stall at pc=5 for 3 cycles, with branch_en asserted to show it is ignored
    rom_a[2] = NOP; rom_a[20] = NOP; rom_a[21] = NOP;
    lut_we_a = 1'b1; lut_addr_a = 5'd1; lut_data_a = 10'd200;
    tick();
    lut_we_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (5) tick();
    check("st_pc5",  32'(bus_a.imem_addr), 32'd5);
    check("st_ret5", 32'(retired_a), 32'd5);
    bus_a.stall = 1'b1; bus_a.branch_en = 1'b1;
    #1;
    check("st_valid0", 32'(bus_a.inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_pc",    32'(bus_a.imem_addr), 32'd5);
      check("st_ret",   32'(retired_a), 32'd5);
      check("st_valid", 32'(bus_a.inst_valid), 32'd0);
    end
    bus_a.stall = 1'b0; bus_a.branch_en = 1'b0;
    #1;
    check("st_valid1", 32'(bus_a.inst_valid), 32'd1);
    tick();
    check("st_pc6",  32'(bus_a.imem_addr), 32'd6);
    check("st_ret6", 32'(retired_a), 32'd6);
    tick();
    check("st_pc7",  32'(bus_a.imem_addr), 32'd7);

    // Reset mid-run at pc=7, with start and a table write competing
    reset = 1'b1; start_a = 1'b1;
    lut_we_a = 1'b1; lut_addr_a = 5'd3; lut_data_a = 10'd99;
    tick();
    check("mr_pc",    32'(bus_a.imem_addr), 32'd0);
    check("mr_ret",   32'(retired_a), 32'd0);
    check("mr_done",  32'(done_a), 32'd0);
    check("mr_valid", 32'(bus_a.inst_valid), 32'd0);
    check("mr_inst",  32'(bus_a.inst), 32'd0);
    reset = 1'b0; start_a = 1'b0; lut_we_a = 1'b0;
    #1;
    check("mr_idle", 32'(bus_a.inst_valid), 32'd0);

    // Restart, then branch with a same-cycle write to the same entry
    rom_a[2] = BR_K3; rom_a[20] = TGT_OP; rom_a[21] = HALT;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("mr_restart_pc",    32'(bus_a.imem_addr), 32'd0);
    check("mr_restart_valid", 32'(bus_a.inst_valid), 32'd1);
    tick(); tick();
    bus_a.branch_en = 1'b1;
    lut_we_a = 1'b1; lut_addr_a = 5'd3; lut_data_a = 10'd30;
    tick();
    bus_a.branch_en = 1'b0; lut_we_a = 1'b0;
    check("col_old", 32'(bus_a.imem_addr), 32'd20);
    tick(); tick();
    check("col_done", 32'(done_a), 32'd1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("col_rs_pc", 32'(bus_a.imem_addr), 32'd0);
    tick(); tick();
    bus_a.branch_en = 1'b1; tick(); bus_a.branch_en = 1'b0;
    check("col_new", 32'(bus_a.imem_addr), 32'd30);

    // Wrap and counter saturation on the narrow instance
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("wr_pc0", 32'(bus_b.imem_addr), 32'd0);
    repeat (15) tick();
    check("wr_pc15",  32'(bus_b.imem_addr), 32'd15);
    check("wr_ret15", 32'(retired_b), 32'd15);
    tick();
    check("wr_pcwrap", 32'(bus_b.imem_addr), 32'd0);
    check("wr_sat",    32'(retired_b), 32'd15);
    check("wr_valid",  32'(bus_b.inst_valid), 32'd1);
    tick();
    check("wr_pc1",  32'(bus_b.imem_addr), 32'd1);
    check("wr_sat2", 32'(retired_b), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 10: program counter width in bits.
REQ-002 Parameter CNT_W, default 16: retired-instruction counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins program execution at address 0.
REQ-006 stall  input  1  holds PC and instruction stream while high.
REQ-007 branch_en  input  1  taken-branch indication from the decoder for the current inst.
REQ-008 imem_addr  output  PC_W  instruction memory address; equals pc.
REQ-009 imem_data  input  9  instruction word, combinationally read at imem_addr.
REQ-010 inst  output  9  instruction presented to the decoder; imem_data in RUN, 9'h000 otherwise.
REQ-011 inst_valid  output  1  high when inst is an executing instruction.
REQ-012 lut_we  input  1  branch target table write enable.
REQ-013 lut_addr  input  5  branch target table write index.
REQ-014 lut_data  input  PC_W  branch target table write data.
REQ-015 done  output  1  high while in DONE.
REQ-016 retired  output  CNT_W  count of retired instructions since last start.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: start=1 -> RUN with pc=0 and retired=0; otherwise hold.
REQ-019 RUN, stall=1: pc, retired and state hold; branch_en ignored; inst_valid=0.
REQ-020 RUN, stall=0, inst is HALT (inst[8:5]=4'b1111): -> DONE; pc holds; retired increments.
REQ-021 RUN, stall=0, branch_en=1: pc <= lut[inst[4:0]] next cycle; retired increments.
REQ-022 RUN, stall=0, otherwise: pc <= pc+1 modulo 2^PC_W, so the maximum address wraps to 0; retired increments.
REQ-023 retired saturates at all-ones and does not wrap.
REQ-024 inst_valid = (state==RUN) & ~stall.
REQ-025 branch_en outside RUN, or during stall, shall have no effect.
REQ-026 DONE: done=1; pc and retired hold; start=1 -> RUN with pc=0 and retired=0.
REQ-027 start in RUN is ignored.
REQ-028 Branch target table: 32 entries of PC_W bits, written synchronously when lut_we=1, read combinationally.
REQ-029 Table writes are accepted in any state.
REQ-030 Write and read of the same entry in one cycle: the read returns the old value.
REQ-031 Branch latency: the target instruction is presented on inst exactly one cycle after the branch instruction.

Reset
REQ-032 reset=1: state=IDLE, pc=0, retired=0, done=0, inst_valid=0, inst=9'h000.
REQ-033 reset has priority over start, stall and lut_we, including when asserted mid-RUN.
REQ-034 Table contents are undefined after reset and must be written by software before use.

Structure
REQ-035 Shared package holds: the FSM state enum, the HALT opcode constant 4'b1111 for inst[8:5], and the branch opcode field constants for inst[7:5].
REQ-036 The branch target table is one sub-module, branch_lut.
REQ-037 PC, FSM and counter logic live in instr_fetch.

Verification
REQ-038 Sequential run: reset, start, ROM 0..3 = non-branch ops, address 4 = HALT -> pc 0,1,2,3,4, then done=1 and retired=5.
REQ-039 Taken branch: lut[3]=10'd20, inst at address 2 = 9'h163 (unconditional branch, key 3) with branch_en=1 -> next pc=20 and inst=imem[20].
REQ-040 Stall: assert stall for 3 cycles at pc=5 -> pc stays 5, inst_valid=0, retired unchanged, then execution resumes at 6.
REQ-041 Wrap: PC_W=4, straight-line ROM without HALT -> pc goes 15 then 0.
REQ-042 Reset mid-RUN at pc=7 -> next cycle state=IDLE, pc=0, retired=0; a following start restarts at address 0.
REQ-043 Restart and collision: start in DONE restarts at pc=0; a lut_we to entry 3 in the same cycle as a branch with key 3 -> the old target is used.
